// File: rtl/board_loader.sv
// board_loader: streams 16 tiles into a 4x4 sliding-puzzle board,
// checks for duplicate tiles and solvability, then starts the Solver.
// Ports:
//   i_clk, i_rst        clock, async active-high reset
//   i_valid, i_tile     tile stream (row-major, top-left first; 0 = blank)
//   i_clear             abort load / acknowledge error
//   i_solver_done       Solver finished
//   o_klotski           board to the Solver, [r][c], [3][3] = bits 63:60
//   o_start             one-cycle Solver start pulse
//   o_ready, o_busy     loading / solving status
//   o_error, o_err_code 01 duplicate tile, 10 unsolvable
module board_loader (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  input  logic [3:0]             i_tile,
  input  logic                   i_clear,
  input  logic                   i_solver_done,
  output logic [3:0][3:0][3:0]   o_klotski,
  output logic                   o_start,
  output logic                   o_ready,
  output logic                   o_busy,
  output logic                   o_error,
  output logic [1:0]             o_err_code
);

  typedef enum logic [2:0] {
    LOAD,
    CHECK,
    START,
    SOLVE,
    ERROR
  } state_t;

  state_t               state_q;
  logic [4:0]           count_q;
  logic [15:0]          seen_q;
  logic                 dup_q;
  logic [6:0]           inv_q;
  logic [2:0]           brow_q;
  logic [3:0][3:0][3:0] klotski_q;
  logic [1:0]           err_q;

  logic       accept;
  logic       clr;
  logic       is_dup;
  logic [3:0] gt_cnt;

  assign accept = (state_q == LOAD) && i_valid && !i_clear;
  assign is_dup = seen_q[i_tile];

  // Leaving a load for any reason other than a completed board
  // (abort, error acknowledge, Solver done) restarts the trackers.
  assign clr = ((state_q == LOAD || state_q == CHECK ||
                 state_q == ERROR) && i_clear) ||
               ((state_q == SOLVE) && i_solver_done);

  // Earlier tiles larger than the incoming one: its inversion count.
  always_comb begin
    gt_cnt = '0;
    for (int j = 0; j < 16; j++) begin
      if (j > int'(i_tile) && seen_q[j])
        gt_cnt = gt_cnt + 4'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= LOAD;
      count_q   <= '0;
      seen_q    <= '0;
      dup_q     <= 1'b0;
      inv_q     <= '0;
      brow_q    <= '0;
      klotski_q <= '0;
      err_q     <= 2'b00;
    end else begin
      if (clr) begin
        count_q <= '0;
        seen_q  <= '0;
        dup_q   <= 1'b0;
        inv_q   <= '0;
        brow_q  <= '0;
      end else if (accept) begin
        count_q <= count_q + 5'd1;
        seen_q[i_tile] <= 1'b1;
        klotski_q[~count_q[3:2]][~count_q[1:0]] <= i_tile;
        if (is_dup)
          dup_q <= 1'b1;
        if (i_tile != 4'd0 && !is_dup)
          inv_q <= inv_q + 7'(gt_cnt);
        // Row index 3 is the top row, so bottom-relative row is idx+1.
        if (i_tile == 4'd0)
          brow_q <= {1'b0, ~count_q[3:2]} + 3'd1;
      end

      unique case (state_q)
        LOAD: begin
          if (accept && count_q == 5'd15)
            state_q <= CHECK;
        end
        CHECK: begin
          if (i_clear) begin
            state_q <= LOAD;
          end else if (dup_q) begin
            state_q <= ERROR;
            err_q   <= 2'b01;
          end else if (!(inv_q[0] ^ brow_q[0])) begin
            // Even inversions+blank-row parity cannot be solved.
            state_q <= ERROR;
            err_q   <= 2'b10;
          end else begin
            state_q <= START;
          end
        end
        START: state_q <= SOLVE;
        SOLVE: begin
          if (i_solver_done)
            state_q <= LOAD;
        end
        ERROR: begin
          if (i_clear) begin
            state_q <= LOAD;
            err_q   <= 2'b00;
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  assign o_klotski  = klotski_q;
  assign o_ready    = (state_q == LOAD);
  assign o_start    = (state_q == START);
  assign o_busy     = (state_q == SOLVE);
  assign o_error    = (state_q == ERROR);
  assign o_err_code = err_q;

endmodule

// File: tb/tb_board_loader.sv
// tb_board_loader: randomized and directed stimulus for board_loader,
// checked against a pair-counting solvability model.
module tb_board_loader;

  typedef logic [3:0] board_t [16];

  logic                 i_clk = 1'b0;
  logic                 i_rst = 1'b0;
  logic                 i_valid = 1'b0;
  logic [3:0]           i_tile = '0;
  logic                 i_clear = 1'b0;
  logic                 i_solver_done = 1'b0;
  logic [3:0][3:0][3:0] o_klotski;
  logic                 o_start;
  logic                 o_ready;
  logic                 o_busy;
  logic                 o_error;
  logic [1:0]           o_err_code;

  int checks = 0;
  int errors = 0;
  int n_start = 0;

  board_loader dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_valid(i_valid),
    .i_tile(i_tile),
    .i_clear(i_clear),
    .i_solver_done(i_solver_done),
    .o_klotski(o_klotski),
    .o_start(o_start),
    .o_ready(o_ready),
    .o_busy(o_busy),
    .o_error(o_error),
    .o_err_code(o_err_code)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) if (o_start) n_start++;

  // 00 solvable, 01 duplicate, 10 unsolvable
  function automatic logic [1:0] model_code(input board_t b);
    int inv = 0;
    int blank = 0;
    for (int i = 0; i < 16; i++)
      for (int j = i + 1; j < 16; j++)
        if (b[i] == b[j]) return 2'b01;
    for (int i = 0; i < 16; i++) begin
      if (b[i] == 0) blank = i;
      for (int j = i + 1; j < 16; j++)
        if (b[i] != 0 && b[j] != 0 && b[i] > b[j]) inv++;
    end
    if (((inv + (4 - blank / 4)) % 2) == 0) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [63:0] model_board(input board_t b);
    logic [63:0] r = '0;
    for (int k = 0; k < 16; k++) r[(15 - k) * 4 +: 4] = b[k];
    return r;
  endfunction

  function automatic board_t rand_perm();
    board_t b;
    logic [3:0] t;
    int j;
    for (int k = 0; k < 16; k++) b[k] = 4'(k);
    for (int k = 15; k > 0; k--) begin
      j = $urandom_range(0, k);
      t = b[k]; b[k] = b[j]; b[j] = t;
    end
    return b;
  endfunction

  // Entered and left at posedge+1; optional random idle gaps.
  task automatic load_board(input board_t b, input int maxgap);
    int gap;
    for (int k = 0; k < 16; k++) begin
      gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      i_valid = 1'b0;
      repeat (gap) begin @(posedge i_clk); #1; end
      i_valid = 1'b1;
      i_tile  = b[k];
      @(posedge i_clk); #1;
    end
    i_valid = 1'b0;
  endtask

  // Return the DUT to LOAD from START/SOLVE/ERROR/LOAD.
  task automatic release_dut();
    @(posedge i_clk); #1;
    i_clear = 1'b1;
    i_solver_done = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    i_clear = 1'b0;
    i_solver_done = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    @(negedge i_clk);
    checks++;
    if (o_ready !== 1'b1 || o_start !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_status got rdy=%b st=%b bsy=%b want 1 0 0",
               o_ready, o_start, o_busy);
    end
    checks++;
    if (o_error !== 1'b0 || o_err_code !== 2'b00) begin
      errors++;
      $display("FAIL reset_error got %b/%b want 0/00", o_error, o_err_code);
    end
    checks++;
    if (o_klotski !== 64'h0) begin
      errors++;
      $display("FAIL reset_board got %h want 0", o_klotski);
    end
    @(posedge i_clk); #1;
    i_rst = 1'b0;
  endtask

  task automatic test_solvable();
    board_t b;
    int s0;
    logic [63:0] hold;
    for (int k = 0; k < 16; k++) b[k] = (k == 15) ? 4'd0 : 4'(k + 1);
    s0 = n_start;
    load_board(b, 0);
    @(negedge i_clk);
    checks++;
    if (o_start !== 1'b0 || o_ready !== 1'b0 || o_error !== 1'b0) begin
      errors++;
      $display("FAIL solv_check_cycle got st=%b rdy=%b err=%b want 0 0 0",
               o_start, o_ready, o_error);
    end
    @(negedge i_clk);
    checks++;
    if (o_start !== 1'b1) begin
      errors++;
      $display("FAIL solv_start got %b want 1", o_start);
    end
    checks++;
    if (o_klotski !== 64'h123456789ABCDEF0) begin
      errors++;
      $display("FAIL solv_board got %h want 123456789abcdef0", o_klotski);
    end
    @(negedge i_clk);
    checks++;
    if (o_busy !== 1'b1 || o_start !== 1'b0) begin
      errors++;
      $display("FAIL solv_busy got bsy=%b st=%b want 1 0", o_busy, o_start);
    end
    hold = o_klotski;
    @(posedge i_clk); #1;
    i_valid = 1'b1; i_tile = 4'd7; i_clear = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    i_valid = 1'b0; i_clear = 1'b0;
    @(negedge i_clk);
    checks++;
    if (o_busy !== 1'b1 || o_klotski !== hold) begin
      errors++;
      $display("FAIL solv_hold got bsy=%b brd=%h want 1 %h",
               o_busy, o_klotski, hold);
    end
    @(posedge i_clk); #1;
    i_solver_done = 1'b1;
    @(posedge i_clk); #1;
    i_solver_done = 1'b0;
    @(negedge i_clk);
    checks++;
    if (o_ready !== 1'b1 || o_busy !== 1'b0 ||
        o_klotski !== 64'h123456789ABCDEF0) begin
      errors++;
      $display("FAIL solv_done got rdy=%b bsy=%b brd=%h want 1 0 kept",
               o_ready, o_busy, o_klotski);
    end
    checks++;
    if (n_start - s0 !== 1) begin
      errors++;
      $display("FAIL solv_pulses got %0d want 1", n_start - s0);
    end
  endtask

  task automatic test_unsolvable();
    board_t b;
    int s0;
    for (int k = 0; k < 16; k++) b[k] = (k == 15) ? 4'd0 : 4'(k + 1);
    b[13] = 4'd15; b[14] = 4'd14;
    s0 = n_start;
    load_board(b, 0);
    @(negedge i_clk);
    @(negedge i_clk);
    checks++;
    if (o_error !== 1'b1 || o_err_code !== 2'b10 || o_start !== 1'b0) begin
      errors++;
      $display("FAIL unsolv_err got err=%b code=%b st=%b want 1 10 0",
               o_error, o_err_code, o_start);
    end
    repeat (4) @(negedge i_clk);
    checks++;
    if (o_error !== 1'b1 || o_err_code !== 2'b10 || n_start != s0) begin
      errors++;
      $display("FAIL unsolv_hold got err=%b code=%b pulses=%0d want 1 10 0",
               o_error, o_err_code, n_start - s0);
    end
    @(posedge i_clk); #1;
    i_clear = 1'b1;
    @(posedge i_clk); #1;
    i_clear = 1'b0;
    @(negedge i_clk);
    checks++;
    if (o_ready !== 1'b1 || o_error !== 1'b0 || o_err_code !== 2'b00) begin
      errors++;
      $display("FAIL unsolv_clear got rdy=%b err=%b code=%b want 1 0 00",
               o_ready, o_error, o_err_code);
    end
  endtask

  task automatic test_dup();
    board_t b;
    for (int k = 0; k < 16; k++) b[k] = (k < 6) ? 4'(k + 1) : 4'(k);
    b[5] = 4'd5;
    load_board(b, 0);
    @(negedge i_clk);
    checks++;
    if (o_error !== 1'b0) begin
      errors++;
      $display("FAIL dup_early got err=%b want 0", o_error);
    end
    @(negedge i_clk);
    checks++;
    if (o_error !== 1'b1 || o_err_code !== 2'b01) begin
      errors++;
      $display("FAIL dup_code got err=%b code=%b want 1 01",
               o_error, o_err_code);
    end
    @(posedge i_clk); #1;
    i_clear = 1'b1;
    @(posedge i_clk); #1;
    i_clear = 1'b0;
    @(negedge i_clk);
    checks++;
    if (o_ready !== 1'b1 || o_err_code !== 2'b00) begin
      errors++;
      $display("FAIL dup_clear got rdy=%b code=%b want 1 00",
               o_ready, o_err_code);
    end
  endtask

  // Load b, then check outcome and board two cycles after the last tile.
  task automatic test_board(input board_t b, input int maxgap,
                            input string name);
    logic [1:0] exp;
    exp = model_code(b);
    load_board(b, maxgap);
    @(negedge i_clk);
    @(negedge i_clk);
    checks++;
    if (exp == 2'b00) begin
      if (o_start !== 1'b1 || o_error !== 1'b0) begin
        errors++;
        $display("FAIL %s_result got st=%b err=%b code=%b want start",
                 name, o_start, o_error, o_err_code);
      end
    end else if (o_error !== 1'b1 || o_err_code !== exp || o_start !== 1'b0) begin
      errors++;
      $display("FAIL %s_result got st=%b err=%b code=%b want err code %b",
               name, o_start, o_error, o_err_code, exp);
    end
    checks++;
    if (o_klotski !== model_board(b)) begin
      errors++;
      $display("FAIL %s_board got %h want %h", name, o_klotski, model_board(b));
    end
    release_dut();
  endtask

  task automatic test_gaps();
    board_t b;
    b = '{4'd10, 4'd1, 4'd14, 4'd12, 4'd6, 4'd2, 4'd9, 4'd15,
          4'd3, 4'd7, 4'd5, 4'd4, 4'd0, 4'd11, 4'd8, 4'd13};
    test_board(b, 3, "gaps");
  endtask

  task automatic test_clear_mid();
    board_t a;
    a = rand_perm();
    for (int k = 0; k < 7; k++) begin
      i_valid = 1'b1; i_tile = a[k];
      @(posedge i_clk); #1;
    end
    i_valid = 1'b1; i_tile = a[7]; i_clear = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_clear = 1'b0;
    @(negedge i_clk);
    checks++;
    if (o_ready !== 1'b1 || o_error !== 1'b0) begin
      errors++;
      $display("FAIL clrmid_state got rdy=%b err=%b want 1 0",
               o_ready, o_error);
    end
    @(posedge i_clk); #1;
    test_board(rand_perm(), 1, "clrmid");
  endtask

  task automatic test_rst_solve();
    board_t b;
    int s0;
    for (int k = 0; k < 16; k++) b[k] = (k == 15) ? 4'd0 : 4'(k + 1);
    load_board(b, 0);
    repeat (3) @(negedge i_clk);
    s0 = n_start;
    #1 i_rst = 1'b1;
    #1;
    checks++;
    if (o_busy !== 1'b0 || o_ready !== 1'b1 || o_klotski !== 64'h0) begin
      errors++;
      $display("FAIL rst_async got bsy=%b rdy=%b brd=%h want 0 1 0",
               o_busy, o_ready, o_klotski);
    end
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    i_solver_done = 1'b1;
    @(posedge i_clk); #1;
    i_solver_done = 1'b0;
    repeat (4) @(negedge i_clk);
    checks++;
    if (o_ready !== 1'b1 || o_busy !== 1'b0 || n_start != s0) begin
      errors++;
      $display("FAIL rst_after got rdy=%b bsy=%b pulses=%0d want 1 0 0",
               o_ready, o_busy, n_start - s0);
    end
    @(posedge i_clk); #1;
  endtask

  task automatic test_random();
    board_t b;
    int x, y;
    for (int r = 0; r < 8; r++) begin
      b = rand_perm();
      if (r % 3 == 2) begin
        x = $urandom_range(0, 15);
        y = (x + int'($urandom_range(1, 15))) % 16;
        b[x] = b[y];
      end
      test_board(b, 2, "rand");
    end
  endtask

  initial begin
    test_reset();
    test_solvable();
    test_unsolvable();
    test_dup();
    test_gaps();
    test_clear_mid();
    test_rst_solve();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/board_loader.md
BOARD_LOADER -- requirements
Module: board_loader

Interface
REQ-001 SHALL have port i_clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port i_rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port i_valid, input, 1 bit: i_tile is valid this cycle.
REQ-004 SHALL have port i_tile, input, 4 bits: tile value; 0 is the blank.
REQ-005 SHALL have port i_clear, input, 1 bit: abort the current load and restart.
REQ-006 SHALL have port i_solver_done, input, 1 bit: the Solver's o_finished.
REQ-007 SHALL have port o_klotski, output, packed [3:0][3:0][3:0]: board driven to the Solver's i_klotski; [r][c] is row r, column c, and [3][3] is nibble 63:60.
REQ-008 SHALL have port o_start, output, 1 bit: one-cycle pulse driven to the Solver's i_start.
REQ-009 SHALL have port o_ready, output, 1 bit: tiles accepted this cycle.
REQ-010 SHALL have port o_busy, output, 1 bit: the Solver is running.
REQ-011 SHALL have port o_error, output, 1 bit, and port o_err_code, output, 2 bits: 00 none, 01 duplicate tile, 10 unsolvable.

Function
REQ-012 SHALL implement states LOAD, CHECK, START, SOLVE and ERROR.
REQ-013 SHALL drive o_ready=1 only in LOAD, o_start=1 only in START, o_busy=1 only in SOLVE, and o_error=1 only in ERROR.
REQ-014 SHALL, in LOAD, accept a tile on every cycle where i_valid=1 and i_clear=0.
REQ-015 SHALL track accepted tiles with a 5-bit count, 0..16.
REQ-016 SHALL write accepted tile k (k=0..15) to o_klotski[3-k/4][3-k%4]; tiles arrive in row-major reading order, top-left first.
REQ-017 SHALL keep a 16-bit seen mask; accepting a tile whose seen bit is already set sets a sticky dup flag.
REQ-018 SHALL continue accepting tiles after a duplicate, until all 16 tiles are received.
REQ-019 SHALL, for each accepted nonzero tile t without a duplicate, add popcount(seen[15:t+1]) to a 7-bit inversion counter (maximum 105).
REQ-020 SHALL, for an accepted blank, record the blank row counted from the bottom, 1..4 (row index 3 gives 4).
REQ-021 SHALL go from LOAD to CHECK on the cycle after the 16th tile is accepted.
REQ-022 SHALL, in CHECK (one cycle), go to ERROR with code 01 if dup=1.
REQ-023 SHALL, in CHECK, otherwise go to ERROR with code 10 if (inversions + blank_row_from_bottom) is even.
REQ-024 SHALL, in CHECK, otherwise go to START.
REQ-025 SHALL stay in START for exactly one cycle, then go to SOLVE.
REQ-026 SHALL give a fixed latency: 16th tile accepted at edge T gives o_start or o_error high in cycle T+2.
REQ-027 SHALL, in SOLVE, hold o_klotski stable and return to LOAD on the cycle after i_solver_done=1.
REQ-028 SHALL, on return to LOAD, clear count, seen, dup and inversions while keeping o_klotski contents.
REQ-029 SHALL hold ERROR and o_err_code until i_clear=1, then go to LOAD with all trackers cleared and o_err_code=00.
REQ-030 SHALL, on i_clear=1 in LOAD or CHECK, go to LOAD with all trackers cleared.
REQ-031 SHALL give i_clear priority over i_valid in the same cycle; the tile is dropped.
REQ-032 SHALL ignore i_clear in START and SOLVE, since the Solver has no abort.
REQ-033 SHALL ignore i_valid outside LOAD.
REQ-034 SHALL ignore i_solver_done outside SOLVE.

Reset
REQ-035 SHALL, while i_rst=1, force state LOAD and clear count, seen, dup, inversions, blank row and o_klotski (all 0).
REQ-036 SHALL hold o_start=0, o_busy=0, o_error=0, o_err_code=00 and o_ready=1 while i_rst=1.
REQ-037 SHALL abandon any operation on reset assertion mid-load or mid-solve, with no o_start pulse afterwards.

Verification
REQ-038 SHALL cover: tiles 1..15,0 streamed back-to-back -> o_start pulses once, 2 cycles after the last tile; o_klotski=64'h123456789ABCDEF0; o_busy=1 until i_solver_done.
REQ-039 SHALL cover: tiles 1..13,15,14,0 (inversions 1, blank row 1) -> o_error=1, o_err_code=10, no o_start.
REQ-040 SHALL cover: tile 5 sent twice (16 tiles total, no 0) -> o_err_code=01 after the 16th tile; i_clear -> o_ready=1, o_err_code=00.
REQ-041 SHALL cover: board 10,1,14,12,6,2,9,15,3,7,5,4,0,11,8,13 with idle gaps between i_valid pulses -> load completes and the solvability result matches a reference-model parity.
REQ-042 SHALL cover: i_clear together with i_valid after 7 tiles -> tile dropped, count 0; a following legal board loads correctly.
REQ-043 SHALL cover: i_rst pulsed during SOLVE -> o_busy=0, o_ready=1, o_klotski=0 asynchronously, and a later i_solver_done is ignored.
